// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and interrupt FSM states for the ALU flag unit.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1001;

    typedef enum logic [1:0] {
        FLAG_V = 2'd0,
        FLAG_C = 2'd1,
        FLAG_Z = 2'd2,
        FLAG_N = 2'd3
    } flag_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ovf_irq_state_t;

    // ADD and SUB differ only in bit 0, so bits [3:1] identify an arithmetic op.
    function automatic logic op_is_arith(input logic [3:0] ctl);
        return ctl[3:1] == ALU_ADD[3:1];
    endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational next-state N/Z/V computation and C-update enable for one ALU result.
module flag_calc
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         valid,
    input  logic [3:0]   ALU_Control,
    input  logic [N-1:0] num1,
    input  logic [N-1:0] num2,
    input  logic [N-1:0] resultado,
    output logic         n_next,
    output logic         z_next,
    output logic         v_next,
    output logic         is_arith,
    output logic         c_update
);

    logic unused_low_bits;

    // ALU_Control[0] folds the SUB operand inversion into the sign comparison.
    always_comb begin
        is_arith = op_is_arith(ALU_Control);
        n_next   = resultado[N-1];
        z_next   = (resultado == '0);
        v_next   = is_arith
                 & ~(num1[N-1] ^ ALU_Control[0] ^ num2[N-1])
                 & (num1[N-1] ^ resultado[N-1]);
        c_update = valid & is_arith;
    end

    assign unused_low_bits = ^{num1[N-2:0], num2[N-2:0]};

endmodule

// File: rtl/alu_flag_unit.sv
// Registered ALU status flags with sticky overflow, saturating event counter and overflow IRQ.
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int N      = 8,
    parameter int CNT_W  = 8,
    parameter int IRQ_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [3:0]       ALU_Control,
    input  logic [N-1:0]     num1,
    input  logic [N-1:0]     num2,
    input  logic [N-1:0]     resultado,
    input  logic             carry_out,
    input  logic             flag_clear,
    input  logic             ovf_ack,
    output logic [3:0]       flags,
    output logic             flags_valid,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_count,
    output logic             ovf_irq
);

    localparam logic IRQ_ON = (IRQ_EN != 0);

    logic n_next;
    logic z_next;
    logic v_next;
    logic is_arith;
    logic c_update;
    logic ovf_event;
    logic irq_event;

    ovf_irq_state_t irq_state;

    flag_calc #(.N(N)) u_flag_calc (
        .valid       (valid),
        .ALU_Control (ALU_Control),
        .num1        (num1),
        .num2        (num2),
        .resultado   (resultado),
        .n_next      (n_next),
        .z_next      (z_next),
        .v_next      (v_next),
        .is_arith    (is_arith),
        .c_update    (c_update)
    );

    assign ovf_event = valid & is_arith & v_next;
    assign irq_event = ovf_event & IRQ_ON;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags       <= '0;
            flags_valid <= 1'b0;
            sticky_v    <= 1'b0;
            ovf_count   <= '0;
            irq_state   <= IDLE;
            ovf_irq     <= 1'b0;
        end else begin
            flags_valid <= valid;
            if (valid) begin
                flags[FLAG_N] <= n_next;
                flags[FLAG_Z] <= z_next;
                flags[FLAG_V] <= v_next;
            end
            if (c_update) begin
                flags[FLAG_C] <= carry_out;
            end

            // A clear coinciding with an event restarts the count at one.
            if (flag_clear) begin
                sticky_v  <= ovf_event;
                ovf_count <= ovf_event ? CNT_W'(1) : '0;
            end else if (ovf_event) begin
                sticky_v <= 1'b1;
                if (ovf_count != '1) begin
                    ovf_count <= ovf_count + CNT_W'(1);
                end
            end

            case (irq_state)
                IDLE: begin
                    if (irq_event) begin
                        irq_state <= PEND;
                        ovf_irq   <= 1'b1;
                    end
                end
                PEND: begin
                    if (ovf_ack && !irq_event) begin
                        irq_state <= IDLE;
                        ovf_irq   <= 1'b0;
                    end
                end
                default: begin
                    irq_state <= IDLE;
                    ovf_irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Table-driven scoreboard bench for alu_flag_unit, with hand-written reset and IRQ sequences.
module tb_alu_flag_unit;

    typedef struct {
        logic [3:0] ctl;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       vld;
        logic       clr;
        logic       ack;
        logic [3:0] e_flags;
        logic       e_fv;
        logic       e_sticky;
        logic [1:0] e_cnt;
        logic       e_irq;
    } vec_t;

    typedef struct {
        logic [3:0] flags;
        logic       fv;
        logic       sticky;
        logic [1:0] cnt;
        logic       irq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] ALU_Control = '0;
    logic [7:0] num1 = '0;
    logic [7:0] num2 = '0;
    logic [7:0] resultado = '0;
    logic       carry_out = 1'b0;
    logic       flag_clear = 1'b0;
    logic       ovf_ack = 1'b0;

    logic [3:0] flags_a;
    logic       fv_a;
    logic       sticky_a;
    logic [1:0] cnt_a;
    logic       irq_a;

    logic [3:0] flags_b;
    logic       fv_b;
    logic       sticky_b;
    logic [7:0] cnt_b;
    logic       irq_b;

    int n_vec  = 0;
    int n_miss = 0;

    exp_t exp_q[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    alu_flag_unit #(.N(8), .CNT_W(2), .IRQ_EN(1)) dut_a (
        .clk (clk), .rst (rst), .valid (valid), .ALU_Control (ALU_Control),
        .num1 (num1), .num2 (num2), .resultado (resultado), .carry_out (carry_out),
        .flag_clear (flag_clear), .ovf_ack (ovf_ack),
        .flags (flags_a), .flags_valid (fv_a), .sticky_v (sticky_a),
        .ovf_count (cnt_a), .ovf_irq (irq_a)
    );

    alu_flag_unit #(.N(8), .CNT_W(8), .IRQ_EN(0)) dut_b (
        .clk (clk), .rst (rst), .valid (valid), .ALU_Control (ALU_Control),
        .num1 (num1), .num2 (num2), .resultado (resultado), .carry_out (carry_out),
        .flag_clear (flag_clear), .ovf_ack (ovf_ack),
        .flags (flags_b), .flags_valid (fv_b), .sticky_v (sticky_b),
        .ovf_count (cnt_b), .ovf_irq (irq_b)
    );

    function automatic vec_t mk(input logic [3:0] ctl, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] res, input logic cout, input logic vld,
                                input logic clr, input logic ack, input logic [3:0] ef,
                                input logic efv, input logic est, input logic [1:0] ec,
                                input logic ei);
        vec_t v;
        v.ctl = ctl; v.a = a; v.b = b; v.res = res; v.cout = cout;
        v.vld = vld; v.clr = clr; v.ack = ack;
        v.e_flags = ef; v.e_fv = efv; v.e_sticky = est; v.e_cnt = ec; v.e_irq = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        ALU_Control = v.ctl; num1 = v.a; num2 = v.b; resultado = v.res;
        carry_out = v.cout; valid = v.vld; flag_clear = v.clr; ovf_ack = v.ack;
        e.flags = v.e_flags; e.fv = v.e_fv; e.sticky = v.e_sticky; e.cnt = v.e_cnt; e.irq = v.e_irq;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            got = exp_q.pop_front();
            chk({tag, " flags"},    int'(flags_a),  int'(got.flags));
            chk({tag, " valid"},    int'(fv_a),     int'(got.fv));
            chk({tag, " sticky"},   int'(sticky_a), int'(got.sticky));
            chk({tag, " count"},    int'(cnt_a),    int'(got.cnt));
            chk({tag, " irq"},      int'(irq_a),    int'(got.irq));
            chk({tag, " b_flags"},  int'(flags_b),  int'(got.flags));
            chk({tag, " b_irq"},    int'(irq_b),    0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //        ctl    a      b      res   co  v  clr ack  flags   fv st cnt irq
        vecs[0]  = mk(4'h8, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd1, 1);
        vecs[1]  = mk(4'h9, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 0, 4'b0011, 1, 1, 2'd2, 1);
        vecs[2]  = mk(4'h9, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 4'b0110, 1, 1, 2'd2, 1);
        vecs[3]  = mk(4'h0, 8'hAA, 8'h55, 8'h12, 1, 0, 0, 0, 4'b0110, 0, 1, 2'd2, 1);
        vecs[4]  = mk(4'h8, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 1, 4'b0110, 1, 1, 2'd2, 0);
        vecs[5]  = mk(4'h0, 8'hF0, 8'h0F, 8'h00, 0, 1, 0, 0, 4'b0110, 1, 1, 2'd2, 0);
        vecs[6]  = mk(4'h2, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 4'b1010, 1, 1, 2'd2, 0);
        vecs[7]  = mk(4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 4'b1010, 0, 1, 2'd2, 0);
        vecs[8]  = mk(4'h8, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd3, 1);
        vecs[9]  = mk(4'h8, 8'h40, 8'h40, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd3, 1);
        vecs[10] = mk(4'h9, 8'h80, 8'h01, 8'h7F, 1, 1, 0, 1, 4'b0011, 1, 1, 2'd3, 1);
        vecs[11] = mk(4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 4'b0011, 0, 1, 2'd3, 0);
        vecs[12] = mk(4'h8, 8'h7F, 8'h01, 8'h80, 0, 1, 1, 0, 4'b1001, 1, 1, 2'd1, 1);
        vecs[13] = mk(4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0, 4'b1001, 0, 0, 2'd0, 1);
        vecs[14] = mk(4'hA, 8'h7F, 8'h01, 8'h80, 1, 1, 0, 0, 4'b1000, 1, 0, 2'd0, 1);
        vecs[15] = mk(4'h9, 8'h7F, 8'hFF, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd1, 1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset flags",  int'(flags_a),  0);
        chk("reset valid",  int'(fv_a),     0);
        chk("reset sticky", int'(sticky_a), 0);
        chk("reset count",  int'(cnt_a),    0);
        chk("reset irq",    int'(irq_a),    0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Drive the counter back to saturation with the IRQ pending, then reset between edges.
        apply(mk(4'h8, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd2, 1), "pre_rst1");
        apply(mk(4'h8, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd3, 1), "pre_rst2");
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async flags",  int'(flags_a),  0);
        chk("async valid",  int'(fv_a),     0);
        chk("async sticky", int'(sticky_a), 0);
        chk("async count",  int'(cnt_a),    0);
        chk("async irq",    int'(irq_a),    0);

        // An operation presented while reset is held must leave no trace.
        @(negedge clk);
        ALU_Control = 4'h8; num1 = 8'h7F; num2 = 8'h01; resultado = 8'h80;
        carry_out = 1'b1; valid = 1'b1;
        @(posedge clk);
        #1;
        chk("in_rst flags", int'(flags_a), 0);
        chk("in_rst count", int'(cnt_a),   0);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst flags", int'(flags_a), 0);
        chk("post_rst irq",   int'(irq_a),   0);

        apply(mk(4'h8, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 0, 4'b1001, 1, 1, 2'd1, 1), "post_rst_evt");
        apply(mk(4'h0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 4'b1001, 0, 1, 2'd1, 0), "post_rst_ack");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
